// File: rtl/pla_req_pkg.sv
// Shared types and helpers for the PLA request frame transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pla_req_pkg;

    // One state per frame word on the wire, plus idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } req_state_t;

    localparam logic [15:0] PLA_REQ_MAGIC    = 16'h504C;
    localparam logic [7:0]  PLA_REQ_SEQ_INIT = 8'h00;
    localparam int unsigned PLA_REQ_WORDS    = 3;

    // Ordinal (1-based) of the word a state presents; 0 when idle.
    function automatic int unsigned pla_req_word_num(input req_state_t st);
        case (st)
            ST_W0:   return 1;
            ST_W1:   return 2;
            ST_W2:   return 3;
            default: return 0;
        endcase
    endfunction

    // 16-bit XOR fold over both halves of word0/word1 and the drop count.
    function automatic logic [15:0] pla_req_chk(input logic [31:0] w0,
                                                input logic [31:0] w1,
                                                input logic [15:0] drop);
        return w0[31:16] ^ w0[15:0] ^ w1[31:16] ^ w1[15:0] ^ drop;
    endfunction

endpackage

// File: rtl/pla_req_chk16.sv
// Check field for word2: XOR fold of word0, word1 and the drop snapshot.
// Latency: combinational.
// Backpressure: none; inputs come from the frame snapshot and are stable.
module pla_req_chk16
    import pla_req_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [15:0] drop,
    output logic [15:0] chk
);

    assign chk = pla_req_chk(w0, w1, drop);

endmodule

// File: rtl/pla_request_frame_tx.sv
// Turns each request edge into a 3-word PLA request frame; one request buffered, overflow counted.
// Latency: first word valid (with sop) one clock after the request edge; back-to-back frames have no bubble.
// Backpressure: valid/ready; a word is held (data/sop/eop stable) until ready, link not rechecked mid-frame.
module pla_request_frame_tx
    import pla_req_pkg::*;
#(
    parameter logic [15:0] P_MAGIC    = PLA_REQ_MAGIC,
    parameter logic [7:0]  P_SEQ_INIT = PLA_REQ_SEQ_INIT
) (
    input  logic        I_pla_main_clk,
    input  logic        I_pla_rst_n,
    input  logic        I_cnt_value_clr,
    input  logic        I_pla_request,
    input  logic [31:0] I_pla_current_freq,
    input  logic [3:0]  I_txpla_acm_mode,
    input  logic        I_tx_link,
    input  logic        I_req_ready,
    output logic [31:0] O_req_data,
    output logic        O_req_valid,
    output logic        O_req_sop,
    output logic        O_req_eop,
    output logic [15:0] O_req_drop_cnt,
    output logic [15:0] O_req_frame_cnt
);

    req_state_t  state, state_n;
    logic        req_d, link_d;
    logic        pending, pending_n;
    logic [7:0]  seq, seq_n;
    logic [15:0] drop_cnt, drop_n;
    logic [15:0] frame_cnt, frame_n;
    logic [3:0]  acm_snap, acm_snap_n;
    logic [31:0] freq_snap, freq_snap_n;
    logic [15:0] drop_snap, drop_snap_n;
    logic [7:0]  seq_snap, seq_snap_n;
    logic [31:0] data_q, data_n;
    logic        valid_q, valid_n, sop_q, sop_n, eop_q, eop_n;

    logic        trig, link_fall, word_acc, eop_acc;
    logic        pend_kept, pend_any, drop_inc, start;
    logic [31:0] w0_snap;
    logic [15:0] chk;

    // A request is the rising edge of the stretched pulse.
    assign trig      = I_pla_request & ~req_d;
    assign link_fall = link_d & ~I_tx_link;
    assign word_acc  = valid_q & I_req_ready;
    assign eop_acc   = word_acc & eop_q;

    // A link drop discards the buffered request first; a new edge then occupies the
    // (possibly just emptied) buffer, or is lost if the buffer is still full.
    assign pend_kept = pending & ~link_fall;
    assign pend_any  = pend_kept | trig;
    assign drop_inc  = (pending & link_fall) | (trig & pend_kept);

    // New frames start from idle or straight out of the last word's handshake.
    assign start = pend_any & I_tx_link & ((state == ST_IDLE) | eop_acc);

    assign w0_snap = {P_MAGIC, acm_snap, 4'h0, seq_snap};

    pla_req_chk16 u_chk16 (
        .w0   (w0_snap),
        .w1   (freq_snap),
        .drop (drop_snap),
        .chk  (chk)
    );

    // Next-state, counters, snapshot and registered stream outputs.
    always_comb begin
        state_n     = state;
        pending_n   = start ? 1'b0 : pend_any;
        seq_n       = seq;
        frame_n     = frame_cnt;
        drop_n      = drop_cnt;
        acm_snap_n  = acm_snap;
        freq_snap_n = freq_snap;
        drop_snap_n = drop_snap;
        seq_snap_n  = seq_snap;
        data_n      = data_q;

        if (I_cnt_value_clr) begin
            seq_n   = P_SEQ_INIT;
            frame_n = '0;
            drop_n  = '0;
        end else begin
            if (eop_acc) begin
                seq_n   = seq + 8'd1;
                frame_n = frame_cnt + 16'd1;
            end
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_n = drop_cnt + 16'd1;
            end
        end

        case (state)
            ST_IDLE: data_n = '0;
            ST_W0: if (word_acc) begin
                state_n = ST_W1;
                data_n  = freq_snap;
            end
            ST_W1: if (word_acc) begin
                state_n = ST_W2;
                data_n  = {drop_snap, chk};
            end
            ST_W2: if (word_acc) begin
                state_n = ST_IDLE;
                data_n  = '0;
            end
            default: state_n = ST_IDLE;
        endcase

        // The sequence number of a back-to-back frame already reflects the eop just accepted.
        if (start) begin
            state_n     = ST_W0;
            acm_snap_n  = I_txpla_acm_mode;
            freq_snap_n = I_pla_current_freq;
            drop_snap_n = drop_cnt;
            seq_snap_n  = seq_n;
            data_n      = {P_MAGIC, I_txpla_acm_mode, 4'h0, seq_n};
        end

        valid_n = (state_n != ST_IDLE);
        sop_n   = (state_n == ST_W0);
        eop_n   = (pla_req_word_num(state_n) == PLA_REQ_WORDS);
    end

    // State register with synchronous active-low reset; reset abandons any frame in flight.
    always_ff @(posedge I_pla_main_clk) begin
        if (!I_pla_rst_n) begin
            state     <= ST_IDLE;
            req_d     <= 1'b0;
            link_d    <= 1'b0;
            pending   <= 1'b0;
            seq       <= P_SEQ_INIT;
            drop_cnt  <= '0;
            frame_cnt <= '0;
            acm_snap  <= '0;
            freq_snap <= '0;
            drop_snap <= '0;
            seq_snap  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state     <= state_n;
            req_d     <= I_pla_request;
            link_d    <= I_tx_link;
            pending   <= pending_n;
            seq       <= seq_n;
            drop_cnt  <= drop_n;
            frame_cnt <= frame_n;
            acm_snap  <= acm_snap_n;
            freq_snap <= freq_snap_n;
            drop_snap <= drop_snap_n;
            seq_snap  <= seq_snap_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            sop_q     <= sop_n;
            eop_q     <= eop_n;
        end
    end

    assign O_req_data      = data_q;
    assign O_req_valid     = valid_q;
    assign O_req_sop       = sop_q;
    assign O_req_eop       = eop_q;
    assign O_req_drop_cnt  = drop_cnt;
    assign O_req_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_pla_request_frame_tx.sv
// Self-checking bench for pla_request_frame_tx: table vectors, directed corner sequences, random run.
// Latency: n/a.
// Backpressure: ready is driven by the bench (fixed or random).
module tb_pla_request_frame_tx;

    localparam logic [15:0] MAGIC    = 16'h504C;
    localparam logic [7:0]  SEQ_INIT = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs, updated only inside step()
    logic        rst_n = 1'b0, clr = 1'b0, req = 1'b0, link = 1'b0, ready = 1'b0;
    logic [31:0] freq = '0;
    logic [3:0]  acm = '0;
    // values the next step() will drive
    logic        d_rst_n = 1'b0, d_clr = 1'b0, d_req = 1'b0, d_link = 1'b1, d_ready = 1'b1;
    logic [31:0] d_freq = '0;
    logic [3:0]  d_acm = '0;

    logic [31:0] data;
    logic        valid, sop, eop;
    logic [15:0] drop_cnt, frame_cnt;

    pla_request_frame_tx dut (
        .I_pla_main_clk     (clk),
        .I_pla_rst_n        (rst_n),
        .I_cnt_value_clr    (clr),
        .I_pla_request      (req),
        .I_pla_current_freq (freq),
        .I_txpla_acm_mode   (acm),
        .I_tx_link          (link),
        .I_req_ready        (ready),
        .O_req_data         (data),
        .O_req_valid        (valid),
        .O_req_sop          (sop),
        .O_req_eop          (eop),
        .O_req_drop_cnt     (drop_cnt),
        .O_req_frame_cnt    (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input logic [31:0] a, input logic [31:0] b, input logic [15:0] d);
        return a[31:16] ^ a[15:0] ^ b[31:16] ^ b[15:0] ^ d;
    endfunction

    // Reference model: request buffer of one, expected words queued per frame.
    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } word_t;

    word_t       m_wq[$];
    logic [31:0] got_w[$];
    logic        m_armed = 1'b0, m_rst_chk = 1'b0, m_sop_due = 1'b0, m_stall = 1'b0;
    logic        m_req_d = 1'b0, m_link_d = 1'b0, m_owed = 1'b0, m_inflight = 1'b0;
    logic [7:0]  m_seq = SEQ_INIT;
    logic [15:0] m_drop = '0, m_frames = '0;
    logic [33:0] m_hold = '0;

    task automatic step();
        word_t       e;
        logic        trig, lfall, free, st, dinc, owed, acc, eop_acc;
        logic [7:0]  seq_nx;
        logic [31:0] w0;
        @(negedge clk);
        if (m_armed) begin
            chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (m_rst_chk) chk("reset_outputs", 64'({valid, sop, eop, data}), 64'(0));
            if (m_sop_due) chk("sop_after_start", 64'({valid, sop}), 64'(2'b11));
            if (m_stall)   chk("stall_hold", 64'({valid, sop, eop, data}), 64'({1'b1, m_hold}));
            if (!m_inflight) chk("idle_valid", 64'(valid), 64'(0));
        end
        rst_n = d_rst_n; clr = d_clr; req = d_req; link = d_link;
        ready = d_ready; freq = d_freq; acm = d_acm;
        m_rst_chk = 1'b0; m_sop_due = 1'b0; m_stall = 1'b0;
        if (!d_rst_n) begin
            m_req_d = 1'b0; m_link_d = 1'b0; m_owed = 1'b0; m_inflight = 1'b0;
            m_seq = SEQ_INIT; m_drop = '0; m_frames = '0; m_wq.delete();
            m_armed = 1'b1; m_rst_chk = 1'b1;
            return;
        end
        acc = valid & d_ready;
        eop_acc = 1'b0;
        if (acc) begin
            got_w.push_back(data);
            if (m_wq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_word: actual %h required none", data);
            end else begin
                e = m_wq.pop_front();
                chk("word", 64'({sop, eop, data}), 64'({e.sop, e.eop, e.d}));
                eop_acc = e.eop;
            end
        end
        if (valid && !d_ready) begin
            m_stall = 1'b1;
            m_hold = {sop, eop, data};
        end
        trig  = d_req & ~m_req_d;
        lfall = m_link_d & ~d_link;
        free  = !m_inflight || eop_acc;
        owed  = m_owed;
        dinc  = 1'b0;
        if (lfall && owed) begin dinc = 1'b1; owed = 1'b0; end
        if (trig) begin
            if (owed) dinc = 1'b1;
            owed = 1'b1;
        end
        st = free && d_link && owed;
        seq_nx = d_clr ? SEQ_INIT : (eop_acc ? m_seq + 8'd1 : m_seq);
        if (st) begin
            w0 = {MAGIC, d_acm, 4'h0, seq_nx};
            m_wq.push_back('{d: w0, sop: 1'b1, eop: 1'b0});
            m_wq.push_back('{d: d_freq, sop: 1'b0, eop: 1'b0});
            m_wq.push_back('{d: {m_drop, fold(w0, d_freq, m_drop)}, sop: 1'b0, eop: 1'b1});
            owed = 1'b0;
        end
        m_inflight = st ? 1'b1 : (eop_acc ? 1'b0 : m_inflight);
        if (d_clr) begin
            m_drop = '0; m_frames = '0;
        end else begin
            if (dinc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            if (eop_acc) m_frames = m_frames + 16'd1;
        end
        m_seq = seq_nx; m_req_d = d_req; m_link_d = d_link; m_owed = owed; m_sop_due = st;
    endtask

    task automatic pulse(input int hi, input int lo);
        d_req = 1'b1;
        repeat (hi) step();
        d_req = 1'b0;
        repeat (lo) step();
    endtask

    typedef struct {
        logic [3:0]  acm;
        logic [31:0] freq;
        logic [31:0] w0, w1, w2;
    } vec_t;

    vec_t tv[4];
    int   r_cnt;

    initial begin
        tv[0] = '{4'h5, 32'h8000_1234, 32'h504C_5000, 32'h8000_1234, 32'h0000_9278};
        tv[1] = '{4'hA, 32'hDEAD_BEEF, 32'h504C_A001, 32'hDEAD_BEEF, 32'h0000_900F};
        tv[2] = '{4'hF, 32'h0000_0000, 32'h504C_F002, 32'h0000_0000, 32'h0000_A04E};
        tv[3] = '{4'h0, 32'hFFFF_FFFF, 32'h504C_0003, 32'hFFFF_FFFF, 32'h0000_504F};

        // reset
        d_rst_n = 1'b0;
        step(); step();
        d_rst_n = 1'b1;
        step();

        // single frames from the table, link up and ready high
        for (int i = 0; i < 4; i++) begin
            got_w.delete();
            d_acm = tv[i].acm; d_freq = tv[i].freq;
            d_req = 1'b1;
            step(); step();
            chk("latency_sop_w0", 64'({valid, sop, data}), 64'({2'b11, tv[i].w0}));
            d_req = 1'b0;
            repeat (6) step();
            chk("frame_len", 64'(got_w.size()), 64'(3));
            if (got_w.size() == 3) begin
                chk("tbl_w0", 64'(got_w[0]), 64'(tv[i].w0));
                chk("tbl_w1", 64'(got_w[1]), 64'(tv[i].w1));
                chk("tbl_w2", 64'(got_w[2]), 64'(tv[i].w2));
            end
            if (i == 0) chk("frame_cnt_first", 64'(frame_cnt), 64'(1));
        end

        // ready low for 5 cycles while word1 is presented
        got_w.delete();
        d_acm = 4'h3; d_freq = 32'h1234_5678;
        d_req = 1'b1; step(); step();
        d_req = 1'b0; d_ready = 1'b0;
        repeat (5) step();
        chk("stall_w1", 64'({valid, data}), 64'({1'b1, 32'h1234_5678}));
        d_ready = 1'b1;
        repeat (5) step();
        chk("stall_len", 64'(got_w.size()), 64'(3));
        if (got_w.size() == 3) chk("stall_w1_acc", 64'(got_w[1]), 64'(32'h1234_5678));

        // three requests during backpressure: one in flight, one pending, one dropped
        d_clr = 1'b1; step(); d_clr = 1'b0;
        got_w.delete();
        d_ready = 1'b0;
        repeat (3) pulse(2, 2);
        chk("burst_drop", 64'(drop_cnt), 64'(1));
        d_ready = 1'b1;
        repeat (10) step();
        chk("burst_len", 64'(got_w.size()), 64'(6));
        if (got_w.size() == 6) begin
            chk("burst_seq0", 64'(got_w[0][7:0]), 64'(0));
            chk("burst_seq1", 64'(got_w[3][7:0]), 64'(1));
            chk("burst_drop_field", 64'(got_w[5][31:16]), 64'(1));
        end

        // request while link down is served when link returns
        d_clr = 1'b1; step(); d_clr = 1'b0;
        got_w.delete();
        d_link = 1'b0;
        pulse(2, 4);
        chk("link_down_no_frame", 64'(valid), 64'(0));
        d_link = 1'b1;
        repeat (6) step();
        chk("served_on_link_up", 64'(got_w.size()), 64'(3));
        chk("link_up_no_drop", 64'(drop_cnt), 64'(0));
        // pending request lost when link falls; frame in flight completes
        got_w.delete();
        d_ready = 1'b0;
        pulse(2, 2); pulse(2, 2);
        d_link = 1'b0;
        step(); step();
        chk("link_fall_drop", 64'(drop_cnt), 64'(1));
        d_ready = 1'b1;
        repeat (6) step();
        d_link = 1'b1;
        repeat (6) step();
        chk("link_fall_frames", 64'(got_w.size()), 64'(3));

        // sequence number wrap
        d_clr = 1'b1; step(); d_clr = 1'b0;
        repeat (256) pulse(2, 3);
        chk("frame_cnt_256", 64'(frame_cnt), 64'(256));
        got_w.delete();
        pulse(2, 4);
        chk("wrap_len", 64'(got_w.size()), 64'(3));
        if (got_w.size() == 3) chk("seq_wrap", 64'(got_w[0][7:0]), 64'(0));
        // clear coinciding with eop accept
        d_req = 1'b1; step(); step();
        d_req = 1'b0; step();
        d_clr = 1'b1; step();
        d_clr = 1'b0; step();
        chk("clr_eop_frames", 64'(frame_cnt), 64'(0));
        got_w.delete();
        pulse(2, 4);
        if (got_w.size() == 3) chk("clr_seq_init", 64'(got_w[0][7:0]), 64'(SEQ_INIT));

        // reset while word1 is on the bus
        d_acm = 4'h9;
        d_req = 1'b1; step(); step();
        d_req = 1'b0; d_rst_n = 1'b0; step();
        d_rst_n = 1'b1; step();
        chk("rst_mid_frame", 64'({valid, sop, eop, data, frame_cnt}), 64'(0));
        got_w.delete();
        pulse(2, 4);
        chk("post_rst_len", 64'(got_w.size()), 64'(3));
        if (got_w.size() == 3) chk("post_rst_w0", 64'(got_w[0]), 64'({MAGIC, 4'h9, 4'h0, 8'h00}));

        // randomized traffic against the model
        r_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            d_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) d_link = ~d_link;
            d_clr  = ($urandom_range(0, 63) == 0);
            d_acm  = 4'($urandom);
            d_freq = $urandom;
            if (r_cnt > 0) begin
                d_req = 1'b1;
                r_cnt--;
            end else begin
                d_req = 1'b0;
                if ($urandom_range(0, 3) == 0) r_cnt = ($urandom_range(0, 15) == 0) ? 12 : 2;
            end
            step();
        end
        d_clr = 1'b0; d_link = 1'b1; d_ready = 1'b1; d_req = 1'b0;
        repeat (20) step();
        chk("drain_empty", 64'(m_wq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
